// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result handshake between a requesting master and the serial adder sequencer.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, result, cout
    );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell shared by the serial sequencer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell reused over WIDTH cycles, LSB first,
// with a start/done handshake towards the requesting master.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] result_shift;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sum bits enter at the MSB so the first (LSB) sum lands in bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign result_shift = fa_sum;
        end else begin : g_shift_wn
            assign result_shift = {fa_sum, result_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.op_a;
                    b_sh_d   = bus.op_b;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                result_d = result_shift;
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

endmodule
